// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: data width, NOP encoding, default PC step,
// the IF fetch state encoding and a word-alignment helper.
package pipe_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] INSTR_NOP       = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_STEP_DEFAULT = 32'd4;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_FETCH = 2'd1,
      FS_HOLD  = 2'd2,
      FS_DRAIN = 2'd3
   } fetch_state_t;

   // Instruction fetches are word aligned; low address bits are dropped.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry skid buffer holding one fetched word (pc + instruction) that
// arrived while the IF/ID output was stalled. Clear wins over load, load
// wins over unload.
module if_skid_buf
   import pipe_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_unload,
   input  logic            i_clear,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_instr,
   output logic            o_valid,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_instr
);

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;

   // Entry storage: capture on load, drop on unload or clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_instr <= INSTR_NOP;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end else if (i_unload) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: issues one outstanding request at a time to
// instruction memory, presents fetched words on the IF/ID register, absorbs
// a word that lands during an ID stall in a one-entry skid buffer, and
// flushes/refetches on EX redirects.
//
// Optional build macro IF_PERF_CNT_EN adds the perf_fetch_cnt and
// perf_bubble_cnt saturating counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FS_IDLE  | one cycle after reset release, no request
// FS_FETCH | normal fetching; request driven from the registered r_req
// FS_HOLD  | output stalled with the next word parked in the skid buffer
// FS_DRAIN | redirect seen mid-request; wait for the old ack, discard it
//
// imem_req is registered: the decision to request in the next cycle is taken
// at the clock edge from the current if_valid/id_stall. A word acked while the
// output turned out to be stalled goes to the skid buffer.
module if_fetch_ctrl
   import pipe_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
)(
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            id_stall,
   input  logic            ex_redirect,
   input  logic [XLEN-1:0] ex_target,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_bubble_cnt
`endif
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_drain_addr;
   logic            r_req;
   logic            r_valid;
   logic [XLEN-1:0] r_if_pc;
   logic [XLEN-1:0] r_if_instr;

   logic            w_ack;
   logic            w_out_busy;
   logic            w_skid_load;
   logic            w_skid_unload;
   logic            w_skid_clear;
   logic            w_skid_valid;
   logic [XLEN-1:0] w_skid_pc;
   logic [XLEN-1:0] w_skid_instr;
   logic [XLEN-1:0] w_target;

   // Acks only count against our own live request, so a stray ack left over
   // from before a reset is ignored.
   always_comb begin
      w_ack         = imem_ack && r_req;
      w_out_busy    = r_valid && id_stall;
      w_target      = align_word(ex_target);
      w_skid_clear  = ex_redirect;
      w_skid_load   = !ex_redirect && (r_state == FS_FETCH) && w_ack && w_out_busy;
      w_skid_unload = !ex_redirect && (r_state == FS_HOLD) && !id_stall;
   end

   if_skid_buf u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_skid_load),
      .i_unload (w_skid_unload),
      .i_clear  (w_skid_clear),
      .i_pc     (r_pc),
      .i_instr  (imem_rdata),
      .o_valid  (w_skid_valid),
      .o_pc     (w_skid_pc),
      .o_instr  (w_skid_instr)
   );

   // FSM, fetch PC and request register; redirect takes priority over all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= FS_IDLE;
         r_pc         <= RESET_PC;
         r_drain_addr <= RESET_PC;
         r_req        <= 1'b0;
      end else if (ex_redirect) begin
         r_pc <= w_target;
         case (r_state)
            FS_FETCH: begin
               if (r_req && !imem_ack) begin
                  // Old request must still complete; remember its address.
                  r_state      <= FS_DRAIN;
                  r_drain_addr <= r_pc;
                  r_req        <= 1'b1;
               end else begin
                  r_state <= FS_FETCH;
                  r_req   <= 1'b1;
               end
            end
            FS_DRAIN: begin
               if (w_ack) begin
                  r_state <= FS_FETCH;
               end
               r_req <= 1'b1;
            end
            default: begin
               r_state <= FS_FETCH;
               r_req   <= 1'b1;
            end
         endcase
      end else begin
         case (r_state)
            FS_IDLE: begin
               r_state <= FS_FETCH;
               r_req   <= 1'b1;
            end
            FS_FETCH: begin
               if (w_ack) begin
                  r_pc <= r_pc + PC_STEP;
                  if (w_out_busy) begin
                     r_state <= FS_HOLD;
                     r_req   <= 1'b0;
                  end else begin
                     r_req   <= 1'b1;
                  end
               end else if (!r_req) begin
                  r_req <= !w_out_busy;
               end
            end
            FS_HOLD: begin
               if (!id_stall) begin
                  r_state <= FS_FETCH;
                  r_req   <= 1'b1;
               end
            end
            FS_DRAIN: begin
               if (w_ack) begin
                  r_state <= FS_FETCH;
                  r_req   <= 1'b1;
               end
            end
            default: begin
               r_state <= FS_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   // IF/ID output register: load from memory or skid, hold under stall,
   // drop once consumed so a word is never presented twice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_if_pc    <= '0;
         r_if_instr <= INSTR_NOP;
      end else if (ex_redirect) begin
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            FS_FETCH: begin
               if (w_ack && !w_out_busy) begin
                  r_valid    <= 1'b1;
                  r_if_pc    <= r_pc;
                  r_if_instr <= imem_rdata;
               end else if (r_valid && !id_stall) begin
                  r_valid <= 1'b0;
               end
            end
            FS_HOLD: begin
               if (!id_stall) begin
                  r_valid    <= w_skid_valid;
                  r_if_pc    <= w_skid_pc;
                  r_if_instr <= w_skid_instr;
               end
            end
            default: begin
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = r_req;
   assign imem_addr = (r_state == FS_DRAIN) ? r_drain_addr : r_pc;
   assign if_valid  = r_valid;
   assign if_pc     = r_if_pc;
   assign if_instr  = r_if_instr;

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_bubble;

   // Delivered-word counter, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetch <= '0;
      end else if (r_valid && !id_stall && (r_perf_fetch != 32'hFFFF_FFFF)) begin
         r_perf_fetch <= r_perf_fetch + 32'd1;
      end
   end

   // Empty-output cycles outside IDLE, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_bubble <= '0;
      end else if ((r_state != FS_IDLE) && !r_valid && (r_perf_bubble != 32'hFFFF_FFFF)) begin
         r_perf_bubble <= r_perf_bubble + 32'd1;
      end
   end

   assign perf_fetch_cnt  = r_perf_fetch;
   assign perf_bubble_cnt = r_perf_bubble;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl. A simple wait-state memory model answers
// requests; a second instance with RESET_PC=FFFF_FFFC shares the stimulus to
// exercise PC wrap.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        id_stall, ex_redirect;
   logic [31:0] ex_target;
   logic        if_valid;
   logic [31:0] if_pc, if_instr;

   logic        imem_req2, if_valid2;
   logic [31:0] imem_addr2, if_pc2, if_instr2;

   int checks   = 0;
   int failures = 0;
   int mem_wait = 0;
   int mem_cnt  = 0;

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_bubble_cnt, perf_fetch_cnt2, perf_bubble_cnt2;
`endif

   always #5 clk = ~clk;

   if_fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .id_stall    (id_stall),
      .ex_redirect (ex_redirect),
      .ex_target   (ex_target),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
`endif
   );

   if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req2),
      .imem_addr   (imem_addr2),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .id_stall    (id_stall),
      .ex_redirect (ex_redirect),
      .ex_target   (ex_target),
      .if_valid    (if_valid2),
      .if_pc       (if_pc2),
      .if_instr    (if_instr2)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt  (perf_fetch_cnt2),
      .perf_bubble_cnt (perf_bubble_cnt2)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h4470_7fff;
         32'h0000_0004: return 32'h0000_0000;
         32'h0000_0008: return 32'h4413_ffff;
         default:       return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Apply inputs just after the edge, then let the memory model answer.
   task automatic drive(input logic stall, input logic redir, input logic [31:0] tgt);
      id_stall    = stall;
      ex_redirect = redir;
      ex_target   = tgt;
      #1;
      imem_ack   = imem_req && (mem_cnt >= mem_wait);
      imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      #1;
   endtask

   task automatic tick();
      mem_cnt = (imem_req && !imem_ack) ? mem_cnt + 1 : 0;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_on();
      rst_n       = 1'b0;
      id_stall    = 1'b0;
      ex_redirect = 1'b0;
      ex_target   = 32'd0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;
      mem_cnt     = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_instr [3];

   initial begin
      exp_instr[0] = 32'h4470_7fff;
      exp_instr[1] = 32'h0000_0000;
      exp_instr[2] = 32'h4413_ffff;

      // Reset values, zero-wait streaming, PC wrap on the second instance.
      mem_wait = 0;
      reset_on();
      check_eq("rst_req",   32'(imem_req), 32'd0);
      check_eq("rst_addr",  imem_addr, 32'd0);
      check_eq("rst_valid", 32'(if_valid), 32'd0);
      check_eq("rst_pc",    if_pc, 32'd0);
      check_eq("rst_instr", if_instr, 32'd0);
      check_eq("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'd0);
      check_eq("idle_req", 32'(imem_req), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("c1_req",   32'(imem_req), 32'd1);
      check_eq("c1_addr",  imem_addr, 32'd0);
      check_eq("c1_valid", 32'(if_valid), 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'd0);
         check_eq("zw_valid", 32'(if_valid), 32'd1);
         check_eq("zw_pc",    if_pc, 32'(4 * i));
         check_eq("zw_instr", if_instr, exp_instr[i]);
         if (i == 0) begin
            check_eq("wrap_pc",   if_pc2, 32'hFFFF_FFFC);
            check_eq("wrap_addr", imem_addr2, 32'h0000_0000);
         end
         tick();
      end

      // ID stall for three cycles with pc=4 on the output.
      reset_on();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'd0); tick();
      drive(1'b0, 1'b0, 32'd0); tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("st_pc0", if_pc, 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'd0);
         check_eq("st_valid", 32'(if_valid), 32'd1);
         check_eq("st_pc",    if_pc, 32'd4);
         check_eq("st_instr", if_instr, 32'h0000_0000);
         check_eq("st_req",   32'(imem_req), (i == 0) ? 32'd1 : 32'd0);
         tick();
      end
      drive(1'b0, 1'b0, 32'd0);
      check_eq("rel_pc",  if_pc, 32'd4);
      check_eq("rel_req", 32'(imem_req), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("skid_valid", 32'(if_valid), 32'd1);
      check_eq("skid_pc",    if_pc, 32'd8);
      check_eq("skid_instr", if_instr, 32'h4413_ffff);
      check_eq("resume_req", 32'(imem_req), 32'd1);
      check_eq("resume_addr", imem_addr, 32'd12);
      tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("after_pc",    if_pc, 32'd12);
      check_eq("after_instr", if_instr, 32'hC0DE_000C);
      tick();

      // Two-wait memory, stall while output empty has no effect.
      mem_wait = 2;
      reset_on();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'd0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'd0);
         check_eq("w2_req",   32'(imem_req), 32'd1);
         check_eq("w2_addr",  imem_addr, 32'd0);
         check_eq("w2_valid", 32'(if_valid), 32'd0);
         tick();
      end
      drive(1'b0, 1'b0, 32'd0);
      check_eq("w2_out_valid", 32'(if_valid), 32'd1);
      check_eq("w2_out_pc",    if_pc, 32'd0);
      check_eq("w2_out_instr", if_instr, 32'h4470_7fff);
      check_eq("w2_next_addr", imem_addr, 32'd4);
      tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("w2_no_dup", 32'(if_valid), 32'd0);
      tick();

      // Redirect to 0x42 during a two-wait request.
      reset_on();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'd0); tick();
      drive(1'b0, 1'b1, 32'h0000_0042);
      check_eq("rd_req", 32'(imem_req), 32'd1);
      tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("rd_drain_addr",  imem_addr, 32'd0);
      check_eq("rd_drain_req",   32'(imem_req), 32'd1);
      check_eq("rd_drain_valid", 32'(if_valid), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("rd_ack_valid", 32'(if_valid), 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'd0);
         check_eq("rd_new_addr",  imem_addr, 32'h0000_0040);
         check_eq("rd_flush_valid", 32'(if_valid), 32'd0);
         tick();
      end
      drive(1'b0, 1'b0, 32'd0);
      check_eq("rd_tgt_valid", 32'(if_valid), 32'd1);
      check_eq("rd_tgt_pc",    if_pc, 32'h0000_0040);
      check_eq("rd_tgt_instr", if_instr, 32'hC0DE_0040);
      tick();

      // Redirect coinciding with a zero-wait ack.
      mem_wait = 0;
      reset_on();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'd0); tick();
      drive(1'b0, 1'b1, 32'h0000_0103); tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("ra_valid", 32'(if_valid), 32'd0);
      check_eq("ra_req",   32'(imem_req), 32'd1);
      check_eq("ra_addr",  imem_addr, 32'h0000_0100);
      tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("ra_out_pc",    if_pc, 32'h0000_0100);
      check_eq("ra_out_instr", if_instr, 32'hC0DE_0100);
      tick();

      // Reset pulse mid-request, then a late ack after release.
      mem_wait = 2;
      reset_on();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'd0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'd0); tick();
      end
      drive(1'b1, 1'b0, 32'd0);
      check_eq("mr_valid_pre", 32'(if_valid), 32'd1);
      check_eq("mr_addr_pre",  imem_addr, 32'd4);
      tick();
      drive(1'b1, 1'b0, 32'd0);
      rst_n = 1'b0;
      #1;
      check_eq("mr_req",   32'(imem_req), 32'd0);
      check_eq("mr_addr",  imem_addr, 32'd0);
      check_eq("mr_valid", 32'(if_valid), 32'd0);
      check_eq("mr_pc",    if_pc, 32'd0);
      check_eq("mr_instr", if_instr, 32'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      id_stall = 1'b0;
      mem_cnt  = 0;
      drive(1'b0, 1'b0, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      #1;
      tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("late_ack_valid", 32'(if_valid), 32'd0);
      check_eq("late_ack_req",   32'(imem_req), 32'd1);
      check_eq("late_ack_addr",  imem_addr, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0);
      check_eq("late_ack_valid2", 32'(if_valid), 32'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

endmodule
